fb_arbiter: RTL and testbench

FB_ARBITER -- requirements
Module: fb_arbiter

---
 rtl/fb_arbiter.sv | 171 +++++++++++++++++
 tb/tb_fb_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_arbiter.sv
// Frame-buffer memory arbiter: scan-out reads beat colour fill, which beats
// buffered draw-engine writes, on one single-port synchronous RAM.
module fb_arbiter #(
    parameter int unsigned AW         = 19,
    parameter int unsigned DW         = 3,
    parameter int unsigned MEM_DEPTH  = 307200,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_sc_req,
    input  logic [AW-1:0] i_sc_addr,
    output logic [DW-1:0] o_sc_data,
    output logic          o_sc_valid,
    input  logic          i_wr_valid,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [DW-1:0] i_wr_data,
    output logic          o_wr_ready,
    input  logic          i_clr_start,
    input  logic [DW-1:0] i_clr_color,
    output logic          o_clr_busy,
    output logic          o_mem_en,
    output logic          o_mem_we,
    output logic [AW-1:0] o_mem_addr,
    output logic [DW-1:0] o_mem_wdata,
    input  logic [DW-1:0] i_mem_rdata
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_ent_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_run;
    wr_ent_t         r_fifo [FIFO_DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic [AW-1:0]   r_fill_cnt;
    logic [DW-1:0]   r_clr_color;
    logic            r_sc_valid;

    logic            w_sc_gnt;
    logic            w_free;
    logic            w_full;
    logic            w_empty;
    logic            w_pop;
    logic            w_push;
    logic            w_fill;
    logic            w_fill_last;
    logic            w_clr_go;
    wr_ent_t         w_head;

    // r_run holds every grant and handshake off until the first edge after reset release
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_run <= 1'b0;
        else          r_run <= 1'b1;
    end

    assign w_sc_gnt    = r_run & i_sc_req;
    assign w_free      = r_run & ~i_sc_req;
    assign w_full      = (r_count == CW'(FIFO_DEPTH));
    assign w_empty     = (r_count == '0);
    assign w_head      = r_fifo[r_rd_ptr];
    assign w_pop       = w_free & (r_state == ST_DRAIN) & ~w_empty;
    assign w_fill      = w_free & (r_state == ST_CLEAR);
    assign w_fill_last = w_fill & (r_fill_cnt == AW'(MEM_DEPTH - 1));
    assign w_clr_go    = r_run & i_clr_start & (r_state != ST_CLEAR);
    // A full FIFO still takes a write on a cycle it drains its head
    assign w_push      = r_run & i_wr_valid & (~w_full | w_pop);
    assign o_wr_ready  = r_run & ~w_full;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_clr_go)      w_state_nxt = ST_CLEAR;
                else if (!w_empty) w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (w_clr_go)      w_state_nxt = ST_CLEAR;
                else if (w_empty)  w_state_nxt = ST_IDLE;
            end
            ST_CLEAR: begin
                if (w_fill_last)   w_state_nxt = w_empty ? ST_IDLE : ST_DRAIN;
            end
            default:               w_state_nxt = ST_IDLE;
        endcase
    end

    // One memory-port owner per cycle, chosen by fixed priority
    always_comb begin
        o_mem_en    = 1'b0;
        o_mem_we    = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        o_clr_busy  = (r_state == ST_CLEAR);
        if (w_sc_gnt) begin
            o_mem_en   = 1'b1;
            o_mem_addr = i_sc_addr;
        end else if (w_fill) begin
            o_mem_en    = 1'b1;
            o_mem_we    = 1'b1;
            o_mem_addr  = r_fill_cnt;
            o_mem_wdata = r_clr_color;
        end else if (w_pop) begin
            o_mem_en    = 1'b1;
            o_mem_we    = 1'b1;
            o_mem_addr  = w_head.addr;
            o_mem_wdata = w_head.data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_fifo[r_wr_ptr] <= {i_wr_addr, i_wr_data};
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_fill_cnt  <= '0;
            r_clr_color <= '0;
        end else if (w_clr_go) begin
            r_fill_cnt  <= '0;
            r_clr_color <= i_clr_color;
        end else if (w_fill) begin
            r_fill_cnt  <= w_fill_last ? '0 : r_fill_cnt + AW'(1);
        end
    end

    // The RAM output register supplies the read word in the cycle after the grant
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_sc_valid <= 1'b0;
        else          r_sc_valid <= w_sc_gnt;
    end

    assign o_sc_valid = r_sc_valid;
    assign o_sc_data  = r_sc_valid ? i_mem_rdata : '0;

endmodule

// File: tb/tb_fb_arbiter.sv
// Directed bench for fb_arbiter with a behavioural 1-cycle-latency RAM.
module tb_fb_arbiter;

    localparam int unsigned AW = 19;
    localparam int unsigned DW = 3;
    localparam int unsigned D  = 2048;
    localparam int unsigned AI = 11;
    localparam int unsigned FD = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          sc_req = 1'b0;
    logic [AW-1:0] sc_addr = '0;
    logic [DW-1:0] sc_data;
    logic          sc_valid;
    logic          wr_valid = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_ready;
    logic          clr_start = 1'b0;
    logic [DW-1:0] clr_color = '0;
    logic          clr_busy;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic [DW-1:0] mem  [D];
    int            wcnt [D];
    int            base [D];
    logic          loaded = 1'b0;
    logic          live;
    logic          exp_v;
    logic [DW-1:0] exp_d;
    logic          mon_on = 1'b0;
    int            n_chk = 0;
    int            n_bad = 0;

    always #5 clk = ~clk;

    fb_arbiter #(.AW(AW), .DW(DW), .MEM_DEPTH(D), .FIFO_DEPTH(FD)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_sc_req    (sc_req),
        .i_sc_addr   (sc_addr),
        .o_sc_data   (sc_data),
        .o_sc_valid  (sc_valid),
        .i_wr_valid  (wr_valid),
        .i_wr_addr   (wr_addr),
        .i_wr_data   (wr_data),
        .o_wr_ready  (wr_ready),
        .i_clr_start (clr_start),
        .i_clr_color (clr_color),
        .o_clr_busy  (clr_busy),
        .o_mem_en    (mem_en),
        .o_mem_we    (mem_we),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .i_mem_rdata (mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // RAM model; preloaded with word(i) = (5*i+3) mod 8 on the first edge
    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < int'(D); i++) begin
                mem[i]  <= DW'((i * 5 + 3) % 8);
                wcnt[i] <= 0;
            end
            loaded <= 1'b1;
        end else if (mem_en) begin
            if (mem_we) begin
                mem[mem_addr[AI-1:0]]  <= mem_wdata;
                wcnt[mem_addr[AI-1:0]] <= wcnt[mem_addr[AI-1:0]] + 1;
            end else begin
                mem_rdata <= mem[mem_addr[AI-1:0]];
            end
        end
    end

    // Expected scan-out return: valid one cycle after every request once out of reset
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live  <= 1'b0;
            exp_v <= 1'b0;
            exp_d <= '0;
        end else begin
            live  <= 1'b1;
            exp_v <= live && sc_req;
            if (live && sc_req) exp_d <= mem[sc_addr[AI-1:0]];
        end
    end

    always @(negedge clk) begin
        if (mon_on) begin
            if (rst_n && live && sc_req)
                chk("sc_gnt", 32'({mem_en, mem_we, mem_addr}), 32'({1'b1, 1'b0, sc_addr}));
            chk("sc_valid", 32'(sc_valid), 32'(exp_v));
            if (exp_v) chk("sc_data", 32'(sc_data), 32'(exp_d));
        end
    end

    function automatic logic [31:0] port_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        return 32'({2'b11, a, d});
    endfunction

    initial begin
        logic [DW-1:0] rd_tab [3];
        logic [DW-1:0] pp_tab [4];
        int  cyc;
        int  once;
        int  badv;
        logic prev_last;
        logic done;
        logic found;

        rd_tab = '{3'd7, 3'd2, 3'd5};
        pp_tab = '{3'd5, 3'd6, 3'd7, 3'd0};

        // Reset holds the port and handshakes low even with requests pending
        repeat (2) @(posedge clk);
        #1;
        sc_req = 1'b1; sc_addr = AW'(16); wr_valid = 1'b1; clr_start = 1'b1;
        @(negedge clk);
        chk("rst_en",   32'(mem_en), 0);
        chk("rst_we",   32'(mem_we), 0);
        chk("rst_rdy",  32'(wr_ready), 0);
        chk("rst_vld",  32'(sc_valid), 0);
        chk("rst_data", 32'(sc_data), 0);
        chk("rst_busy", 32'(clr_busy), 0);
        step();
        sc_req = 1'b0; wr_valid = 1'b0; clr_start = 1'b0; rst_n = 1'b1;
        @(negedge clk);
        chk("rdy_pre", 32'(wr_ready), 0);
        step();
        @(negedge clk);
        chk("rdy_post", 32'(wr_ready), 1);
        chk("idle_en",  32'(mem_en), 0);
        mon_on = 1'b1;

        // Scan-out of address 0x10 for three cycles; word(16) = 3
        for (int k = 0; k < 3; k++) begin
            step();
            sc_req = 1'b1; sc_addr = AW'(16);
            @(negedge clk);
            chk("so_port", 32'({mem_en, mem_we}), 32'(2'b10));
            if (k > 0) begin
                chk("so_v", 32'(sc_valid), 1);
                chk("so_d", 32'(sc_data), 3);
            end
        end
        step();
        sc_req = 1'b0;
        @(negedge clk);
        chk("so_v4", 32'(sc_valid), 1);
        chk("so_d4", 32'(sc_data), 3);
        step();
        @(negedge clk);
        chk("so_v5", 32'(sc_valid), 0);

        // Back-to-back reads of 100, 107, 114
        for (int k = 0; k < 4; k++) begin
            step();
            sc_req  = (k < 3);
            sc_addr = AW'(100 + 7 * k);
            @(negedge clk);
            if (k > 0) chk("rd_seq", 32'(sc_data), 32'(rd_tab[k-1]));
        end

        // Four writes while scan-out owns every cycle
        step();
        sc_req = 1'b1; sc_addr = AW'(200);
        for (int k = 0; k < 4; k++) begin
            wr_valid = 1'b1; wr_addr = AW'(10 + k); wr_data = DW'(k + 1);
            @(negedge clk);
            chk("bw_rdy", 32'(wr_ready), 1);
            step();
        end
        wr_valid = 1'b0;
        @(negedge clk);
        chk("bw_full", 32'(wr_ready), 0);
        chk("bw_nowe", 32'(mem_we), 0);
        step();
        @(negedge clk);
        chk("bw_nowe2", 32'(mem_we), 0);
        step();
        sc_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("bw_wr", 32'({mem_en, mem_we, mem_addr, mem_wdata}), port_wr(AW'(10 + k), DW'(k + 1)));
            step();
        end
        @(negedge clk);
        chk("bw_rdy2", 32'(wr_ready), 1);
        chk("bw_idle", 32'(mem_en), 0);

        // Full FIFO: drain and push in the same free cycle
        step();
        sc_req = 1'b1; sc_addr = AW'(300);
        for (int k = 0; k < 4; k++) begin
            wr_valid = 1'b1; wr_addr = AW'(20 + k); wr_data = pp_tab[k];
            step();
        end
        wr_valid = 1'b1; wr_addr = AW'(24); wr_data = 3'd1; sc_req = 1'b0;
        @(negedge clk);
        chk("pp_rdy", 32'(wr_ready), 0);
        chk("pp_wr0", 32'({mem_en, mem_we, mem_addr, mem_wdata}), port_wr(AW'(20), 3'd5));
        step();
        wr_valid = 1'b0;
        @(negedge clk);
        chk("pp_cnt", 32'(wr_ready), 0);
        for (int k = 1; k < 4; k++) begin
            chk("pp_wr", 32'({mem_en, mem_we, mem_addr, mem_wdata}), port_wr(AW'(20 + k), pp_tab[k]));
            step();
            @(negedge clk);
        end
        chk("pp_new", 32'({mem_en, mem_we, mem_addr, mem_wdata}), port_wr(AW'(24), 3'd1));
        step();
        @(negedge clk);
        chk("pp_rdy2", 32'(wr_ready), 1);

        // Fill with colour 101, scan-out every other cycle, a draw and an ignored restart
        step();
        clr_start = 1'b1; clr_color = 3'b101;
        @(negedge clk);
        chk("clr_b0", 32'(clr_busy), 0);
        for (int i = 0; i < int'(D); i++) base[i] = wcnt[i];
        step();
        clr_start = 1'b0;
        @(negedge clk);
        chk("clr_b1", 32'(clr_busy), 1);
        cyc = 0; prev_last = 1'b0; done = 1'b0;
        while (cyc < 3 * int'(D) + 100) begin
            step();
            cyc++;
            sc_req    = cyc[0];
            sc_addr   = AW'($urandom_range(0, D - 1));
            wr_valid  = (cyc == 10); wr_addr = AW'(5); wr_data = 3'b010;
            clr_start = (cyc == 20); clr_color = 3'b011;
            @(negedge clk);
            if (!clr_busy) begin
                chk("clr_fall", 32'(prev_last), 1);
                done = 1'b1;
                break;
            end
            prev_last = mem_en && mem_we && (mem_addr == AW'(D - 1));
        end
        chk("clr_done", 32'(done), 1);
        once = 0; badv = 0;
        for (int i = 0; i < int'(D); i++) begin
            if (wcnt[i] - base[i] != 1) once++;
            if (mem[i] !== 3'b101) badv++;
        end
        chk("fill_once", 32'(once), 0);
        chk("fill_val", 32'(badv), 0);
        step();
        sc_req = 1'b0; wr_valid = 1'b0; clr_start = 1'b0;
        repeat (4) step();
        sc_req = 1'b1; sc_addr = AW'(5);
        step();
        sc_addr = AW'(6);
        @(negedge clk);
        chk("rd5_v", 32'(sc_valid), 1);
        chk("rd5", 32'(sc_data), 32'(3'b010));
        step();
        sc_req = 1'b0;
        @(negedge clk);
        chk("rd6", 32'(sc_data), 32'(3'b101));

        // Reset while the fill counter sits at 1000
        step();
        clr_start = 1'b1; clr_color = 3'b110;
        step();
        clr_start = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 1500; k++) begin
            @(negedge clk);
            if (mem_en && mem_we && mem_addr == AW'(1000)) begin
                found = 1'b1;
                break;
            end
            step();
        end
        chk("rmf_found", 32'(found), 1);
        rst_n = 1'b0;
        #1;
        chk("rmf_busy", 32'(clr_busy), 0);
        chk("rmf_we",   32'(mem_we), 0);
        chk("rmf_en",   32'(mem_en), 0);
        chk("rmf_rdy",  32'(wr_ready), 0);
        step();
        rst_n = 1'b1;
        step();
        @(negedge clk);
        chk("rmf_rdy1", 32'(wr_ready), 1);
        chk("rmf_idle", 32'(mem_en), 0);
        chk("rmf_busy1", 32'(clr_busy), 0);
        repeat (3) step();
        @(negedge clk);
        chk("rmf_nowr", 32'(mem_en), 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
